m_prog_loader: RTL and testbench

M_PROG_LOADER -- requirements
Module: m_prog_loader

---
 rtl/loader_pkg.sv | 32 +++
 rtl/m_uart_rx.sv | 115 +++++++++++
 rtl/m_prog_loader.sv | 168 ++++++++++++++++
 tb/tb_m_prog_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Build option: LOADER_CHECKSUM_EN adds the trailing XOR checksum state.
package loader_pkg;

  // Width of the instruction-memory word address.
  localparam int unsigned IMEM_ADDR_W = 11;

  // Default UART bit period in clock cycles.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 100;

  // Frame-level states of the loader.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
`ifdef LOADER_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_DONE,
    ST_ERR
  } loader_state_e;

  // Bit-level states of the UART receiver.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/m_uart_rx.sv
// 8N1 UART byte receiver. Start bit is re-verified at mid-bit so short
// low glitches are dropped; a low stop bit reports a framing error.
// The input line is assumed to be already synchronised to clk.
module m_uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Last cycle of a full bit period, and of the half period used for the start check.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT / 2) - 1);

  rx_state_e        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rxd_prev_q;

  // Bit timing: wait half a bit after the falling edge, then a full bit per sample.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rxd_prev_q && !rxd) begin
          st_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid-bit means it was only a glitch.
          st_d  = rxd ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rxd, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            st_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          if (rxd) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  // Receiver state registers; line history resets to idle-high.
  always_ff @(posedge clk) begin
    if (srst) begin
      st_q       <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      rxd_prev_q <= 1'b1;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      rxd_prev_q <= rxd;
    end
  end

  assign rx_byte      = byte_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/m_prog_loader.sv
// UART program loader: receives a word-count header and N little-endian
// words, writing each into instruction memory while holding the processor
// in reset via r_busy. DONE and ERR are sticky until w_rst.
// Build option: LOADER_CHECKSUM_EN expects a trailing XOR-of-data byte.
module m_prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned MAX_WORDS    = 2048
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   w_rxd,
  output logic                   r_we,
  output logic [IMEM_ADDR_W-1:0] r_addr,
  output logic [31:0]            r_wdata,
  output logic                   r_busy,
  output logic                   r_done,
  output logic                   r_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  m_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (w_clk),
    .srst        (w_rst),
    .rxd         (w_rxd),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  loader_state_e          state_q, state_d;
  logic [15:0]            count_q, count_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [31:0]            word_q, word_d;
  logic                   we_q, we_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [15:0]            next_index;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             cksum_q, cksum_d;
`endif

  // Number of words written once the write currently on the bus completes.
  assign next_index = {{(16 - IMEM_ADDR_W){1'b0}}, addr_q} + 16'd1;

  // Frame sequencing, word assembly and write generation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_frame_err) begin
          state_d = ST_ERR;
        end else if (rx_valid) begin
          count_d[7:0] = rx_byte;
          state_d      = ST_HDR0;
        end
      end
      ST_HDR0: begin
        if (rx_frame_err) begin
          state_d = ST_ERR;
        end else if (rx_valid) begin
          count_d[15:8] = rx_byte;
          state_d       = ST_HDR1;
        end
      end
      ST_HDR1: begin
        // Full count is available; decide before any data byte can arrive.
        if (count_q == 16'd0) begin
          state_d = ST_DONE;
        end else if (32'(count_q) > MAX_WORDS) begin
          state_d = ST_ERR;
        end else begin
          state_d    = ST_DATA;
          byte_idx_d = '0;
        end
      end
      ST_DATA: begin
        // A write is on the bus this cycle: advance the address and
        // finish once the last word has gone out.
        if (we_q) begin
          addr_d = addr_q + 1'b1;
          if (next_index == count_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
        if (rx_frame_err) begin
          state_d = ST_ERR;
        end else if (rx_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
          byte_idx_d = byte_idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          cksum_d = cksum_q ^ rx_byte;
`endif
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = word_d;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CKSUM: begin
        if (rx_frame_err) begin
          state_d = ST_ERR;
        end else if (rx_valid) begin
          state_d = (rx_byte == cksum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  // Loader registers; reset discards any partially assembled word.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign r_we    = we_q;
  assign r_addr  = addr_q;
  assign r_wdata = wdata_q;
  assign r_done  = (state_q == ST_DONE);
  assign r_err   = (state_q == ST_ERR);
  assign r_busy  = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);

endmodule

// File: tb/tb_m_prog_loader.sv
// Self-checking bench for m_prog_loader: table of whole frames plus
// hand-written sequences for glitch, reset, sticky and header-limit cases.
module tb_m_prog_loader;

  localparam int CLKS = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_rxd = 1'b1;
  logic        r_we;
  logic [10:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  m_prog_loader #(
    .CLKS_PER_BIT(CLKS),
    .MAX_WORDS   (2048)
  ) dut (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_rxd  (w_rxd),
    .r_we   (r_we),
    .r_addr (r_addr),
    .r_wdata(r_wdata),
    .r_busy (r_busy),
    .r_done (r_done),
    .r_err  (r_err)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic [127:0]      bytes;   // byte i at [8i+7:8i]
    int                nbytes;
    int                bad_idx; // byte sent with a low stop bit, -1 for none
    logic              exp_done;
    logic              exp_err;
    logic [1:0][10:0]  wa;
    logic [1:0][31:0]  wd;
    int                nwr;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  logic [42:0] exp_q [$];
  logic [42:0] obs_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  // Record every write strobe seen on the memory port.
  always @(negedge w_clk) begin
    if (r_we === 1'b1) begin
      obs_q.push_back({r_addr, r_wdata});
      $display("[TB] write addr=%0d data=0x%08h", r_addr, r_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    w_rst = 1'b1;
    w_rxd = 1'b1;
    repeat (2) @(negedge w_clk);
    w_rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".we"},    {31'd0, r_we},   32'd0);
    check({tag, ".addr"},  {21'd0, r_addr}, 32'd0);
    check({tag, ".wdata"}, r_wdata,         32'd0);
    check({tag, ".busy"},  {31'd0, r_busy}, 32'd0);
    check({tag, ".done"},  {31'd0, r_done}, 32'd0);
    check({tag, ".err"},   {31'd0, r_err},  32'd0);
  endtask

  task automatic send_bit(input logic v);
    w_rxd = v;
    repeat (CLKS) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(!bad_stop);
    w_rxd = 1'b1;
    repeat (CLKS) @(negedge w_clk);
  endtask

  task automatic expect_write(input logic [10:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Pop observed writes against the expected queue.
  task automatic compare_writes(input string tag);
    logic [42:0] e;
    logic [42:0] o;
    check({tag, ".nwrites"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, ".waddr"}, {21'd0, o[42:32]}, {21'd0, e[42:32]});
      check({tag, ".wdata"}, o[31:0], e[31:0]);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_final(input string tag, input logic done, input logic err);
    check({tag, ".done"}, {31'd0, r_done}, {31'd0, done});
    check({tag, ".err"},  {31'd0, r_err},  {31'd0, err});
    check({tag, ".busy"}, {31'd0, r_busy}, 32'd0);
  endtask

  initial begin
    // REQ-032 style frame: two words, checksum 0x04 when enabled.
    vecs[0] = '0;
    vecs[0].bytes    = 128'h04_20_01_00_05_00_00_00_20_00_02;
    vecs[0].nbytes   = 10 + CK;
    vecs[0].bad_idx  = -1;
    vecs[0].exp_done = 1'b1;
    vecs[0].nwr      = 2;
    vecs[0].wa[0] = 11'd0; vecs[0].wd[0] = 32'h0000_0020;
    vecs[0].wa[1] = 11'd1; vecs[0].wd[1] = 32'h2001_0005;
    // Zero-length program.
    vecs[1] = '0;
    vecs[1].bytes    = 128'h00_00;
    vecs[1].nbytes   = 2;
    vecs[1].bad_idx  = -1;
    vecs[1].exp_done = 1'b1;
    // Count one above the memory depth.
    vecs[2] = '0;
    vecs[2].bytes    = 128'h08_01;
    vecs[2].nbytes   = 2;
    vecs[2].bad_idx  = -1;
    vecs[2].exp_err  = 1'b1;
    // Framing error on the third data byte.
    vecs[3] = '0;
    vecs[3].bytes    = 128'h00_00_20_00_02;
    vecs[3].nbytes   = 5;
    vecs[3].bad_idx  = 4;
    vecs[3].exp_err  = 1'b1;
    // Single word with all bytes distinct.
    vecs[4] = '0;
    vecs[4].bytes    = 128'h22_DE_AD_BE_EF_00_01;
    vecs[4].nbytes   = 6 + CK;
    vecs[4].bad_idx  = -1;
    vecs[4].exp_done = 1'b1;
    vecs[4].nwr      = 1;
    vecs[4].wa[0] = 11'd0; vecs[4].wd[0] = 32'hDEAD_BEEF;
`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: both words still written, then error.
    vecs[5] = vecs[0];
    vecs[5].bytes    = 128'h05_20_01_00_05_00_00_00_20_00_02;
    vecs[5].exp_done = 1'b0;
    vecs[5].exp_err  = 1'b1;
`else
    // Single all-zero word.
    vecs[5] = '0;
    vecs[5].bytes    = 128'h00_00_00_00_00_01;
    vecs[5].nbytes   = 6;
    vecs[5].bad_idx  = -1;
    vecs[5].exp_done = 1'b1;
    vecs[5].nwr      = 1;
    vecs[5].wa[0] = 11'd0; vecs[5].wd[0] = 32'h0;
`endif

    do_reset();
    check_reset_outputs("reset");

    for (int v = 0; v < NVEC; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].nwr; k++) expect_write(vecs[v].wa[k], vecs[v].wd[k]);
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        send_byte(vecs[v].bytes[8*i +: 8], i == vecs[v].bad_idx);
        if (i == 0) check($sformatf("vec%0d.busy_after_hdr0", v), {31'd0, r_busy}, 32'd1);
      end
      repeat (8) @(negedge w_clk);
      compare_writes($sformatf("vec%0d", v));
      check_final($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
      $display("[TB] vec%0d done=%0b err=%0b", v, r_done, r_err);
    end

    // Count exactly at the memory depth is accepted and stays busy.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h08, 1'b0);
    repeat (4) @(negedge w_clk);
    check("max_count.busy", {31'd0, r_busy}, 32'd1);
    check("max_count.err",  {31'd0, r_err},  32'd0);
    $display("[TB] max_count busy=%0b err=%0b", r_busy, r_err);

    // Short low glitch is ignored, then a normal frame loads.
    do_reset();
    w_rxd = 1'b0;
    repeat (3) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (2 * CLKS) @(negedge w_clk);
    check("glitch.busy", {31'd0, r_busy}, 32'd0);
    check("glitch.err",  {31'd0, r_err},  32'd0);
    expect_write(11'd0, 32'h1234_5678);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    if (CK == 1) send_byte(8'h08, 1'b0);
    repeat (8) @(negedge w_clk);
    compare_writes("glitch");
    check_final("glitch", 1'b1, 1'b0);
    $display("[TB] glitch frame done=%0b", r_done);

    // DONE is sticky: a further frame produces no writes.
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    repeat (8) @(negedge w_clk);
    compare_writes("sticky");
    check_final("sticky", 1'b1, 1'b0);
    check("sticky.addr", {21'd0, r_addr}, 32'd1);
    $display("[TB] sticky done=%0b addr=%0d", r_done, r_addr);

    // Reset after two bytes of word 0, then a fresh one-word frame.
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_reset();
    check_reset_outputs("midreset");
    expect_write(11'd0, 32'hDDCC_BBAA);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    if (CK == 1) send_byte(8'h00, 1'b0);
    repeat (8) @(negedge w_clk);
    compare_writes("midreset");
    check_final("midreset", 1'b1, 1'b0);
    $display("[TB] midreset frame done=%0b", r_done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
